// File: rtl/ha_serial_add_ctrl.sv
// ha_serial_add_ctrl: bit-serial adder that runs one full-adder cell (two half adders + OR) over WIDTH enabled cycles
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ena          clock enable; all registers hold while low
//   start        request, accepted only in IDLE with ena high
//   cin          carry-in, captured with the operands
//   op_a, op_b   WIDTH-bit operands, captured on an accepted start
//   sum, cout    registered result of the last completed addition
//   busy         high in RUN and DONE
//   done         high for one enabled cycle when a result lands
module ha_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cin,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c, r_cout, r_busy, r_done;
  logic             w_p, w_g, w_s, w_cn;
  // first half adder on the operand bits, second folds in the carry
  assign w_p  = r_a[0] ^ r_b[0];
  assign w_g  = r_a[0] & r_b[0];
  assign w_s  = w_p ^ r_c;
  assign w_cn = w_g | (w_p & r_c);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= op_a;
          r_b     <= op_b;
          r_c     <= cin;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          r_acc <= {w_s, r_acc[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cn;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_sum   <= {w_s, r_acc[WIDTH-1:1]};
            r_cout  <= w_cn;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// tb_ha_serial_add_ctrl: directed and swept checks of the bit-serial adder controller
module tb_ha_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, ena, start, cin;
  logic [7:0] op_a, op_b, sum;
  logic       cout, busy, done;
  int         n_chk = 0, n_pass = 0, n_done = 0;
  ha_serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cin(cin),
    .op_a(op_a), .op_b(op_b), .sum(sum), .cout(cout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done && ena) n_done++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int k;
    op_a = a; op_b = b; cin = ci; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      step();
      k++;
    end
  endtask
  initial begin
    int nb, nd, di, d0, k, en_cnt, f1, f2;
    logic [7:0] s1, s2, a, b;
    logic ci, any_done;
    logic [8:0] ref9;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    step(); step();
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    step();
    // 0x5A + 0x3C: busy for 9 samples, done only on the last
    op_a = 8'h5A; op_b = 8'h3C; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    nb = 0; nd = 0; di = -1;
    for (int i = 0; i < 12; i++) begin
      if (busy) nb++;
      if (done) begin nd++; di = i; end
      if (i == 4) chk("hold_sum_run", sum, 8'h00);
      if (i == 8) begin
        chk("sum_5a3c", sum, 8'h96);
        chk("cout_5a3c", cout, 1'b0);
      end
      step();
    end
    chk("busy_len", nb, 9);
    chk("done_cnt", nd, 1);
    chk("done_pos", di, 8);
    // overflow, then earliest back-to-back start
    run_op(8'hFF, 8'h01, 1'b0);
    chk("sum_ff01", {done, cout, sum}, {1'b1, 1'b1, 8'h00});
    step();
    op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_accepted", busy, 1'b1);
    chk("b2b_hold_prev", {cout, sum}, {1'b1, 8'h00});
    k = 0;
    while (!done && k < 50) begin step(); k++; end
    chk("sum_ffff1", {done, cout, sum}, {1'b1, 1'b1, 8'hFF});
    step();
    // start held high: one op every 10 cycles, mid-run operand change ignored
    op_a = 8'h01; op_b = 8'h02; cin = 1'b0; start = 1'b1;
    step();
    nd = 0; f1 = -1; f2 = -1; s1 = '0; s2 = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin op_a = 8'hAA; op_b = 8'h55; end
      if (done) begin
        nd++;
        if (f1 < 0) begin f1 = i; s1 = sum; end else begin f2 = i; s2 = sum; end
      end
      if (i < 19) step();
    end
    start = 1'b0;
    step();
    chk("held_done_cnt", nd, 2);
    chk("held_first_pos", f1, 8);
    chk("held_second_pos", f2, 18);
    chk("held_sum1", s1, 8'h03);
    chk("held_sum2", s2, 8'hFF);
    chk("held_idle", busy, 1'b0);
    // ena toggling during 0x80 + 0x80
    op_a = 8'h80; op_b = 8'h80; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    k = 0; en_cnt = 0;
    while (!done && k < 40) begin
      ena = (k % 2 == 1);
      step();
      if (ena) en_cnt++;
      k++;
    end
    chk("ena_done", done, 1'b1);
    chk("ena_edges", en_cnt, 8);
    chk("ena_result", {cout, sum}, {1'b1, 8'h00});
    ena = 1'b0;
    step(); step(); step();
    chk("done_stretch", {busy, done}, 2'b11);
    ena = 1'b1;
    step();
    chk("done_release", {busy, done}, 2'b00);
    // async reset mid-run
    op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, done, cout, sum}, 11'h000);
    step();
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      any_done |= done;
      step();
    end
    chk("no_done_after_rst", any_done, 1'b0);
    run_op(8'h0F, 8'h01, 1'b0);
    chk("sum_0f01", {done, cout, sum}, {1'b1, 1'b0, 8'h10});
    step();
    // random sweep
    d0 = n_done;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
      ref9 = {1'b0, a} + {1'b0, b} + {8'h00, ci};
      run_op(a, b, ci);
      chk("rand", {done, cout, sum}, {1'b1, ref9});
      step();
    end
    chk("rand_done_cnt", n_done - d0, 1000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
